decoder42_encoder_seq: RTL

- Registered 4:2 encoder with a valid/ready handshake; the inverse of the team's 2:4 active-low decoder.
- Takes a 4-bit active-low one-cold line vector plus valid, recovers the 2-bit select {a,b} and the disable (en) condition, and flags malformed multi-low patterns.
- Buffers results in a 2-entry output queue so a downstream consumer can stall without losing samples.
- Used for decoder loop-back checking and for turning one-cold strobe buses back into indices.

---
 rtl/decoder42_encoder_seq_if.sv | 26 ++
 rtl/decoder42_encoder_seq.sv | 84 ++++++++
 2 files changed

// File: rtl/decoder42_encoder_seq_if.sv
// Handshake bundle for the registered 4:2 one-cold encoder: input strobe side,
// queued result side and the running malformed-input count.
interface decoder42_encoder_seq_if #(
  parameter int ERRW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      y_n;
  logic            out_valid;
  logic            out_ready;
  logic            a;
  logic            b;
  logic            en_n;
  logic            err;
  logic [ERRW-1:0] err_cnt;

  modport master (
    output in_valid, y_n, out_ready,
    input  in_ready, out_valid, a, b, en_n, err, err_cnt
  );

  modport slave (
    input  in_valid, y_n, out_ready,
    output in_ready, out_valid, a, b, en_n, err, err_cnt
  );
endinterface

// File: rtl/decoder42_encoder_seq.sv
// Registered 4:2 encoder for active-low one-cold line vectors, with a 2-entry
// result FIFO and a saturating count of malformed (multi-low) inputs.
module decoder42_encoder_seq #(
  parameter bit PRIO_HIGH = 1'b1,
  parameter int ERRW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder42_encoder_seq_if.slave bus
);
  typedef struct packed {
    logic a;
    logic b;
    logic en_n;
    logic err;
  } ent_t;

  localparam ent_t ENT_RST = '{a: 1'b0, b: 1'b0, en_n: 1'b1, err: 1'b0};

  ent_t            q0, q1, enc;
  logic [1:0]      count;
  logic [1:0]      win;
  logic [2:0]      nlow;
  logic [ERRW-1:0] err_cnt;
  logic            in_ready, push, pop;

  // Winner is the last low line seen when high priority, else the first one.
  always_comb begin
    enc  = ENT_RST;
    win  = 2'd0;
    nlow = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.y_n[i]) begin
        nlow = nlow + 3'd1;
        if (PRIO_HIGH || nlow == 3'd1) win = 2'(i);
      end
    end
    if (nlow != 3'd0) enc = '{a: win[1], b: win[0], en_n: 1'b0, err: (nlow > 3'd1)};
  end

  // Readiness depends only on state and rst, never on out_ready.
  assign in_ready = ~rst & (count != 2'd2);
  assign push     = bus.in_valid & in_ready;
  assign pop      = bus.out_ready & (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      q0      <= ENT_RST;
      q1      <= ENT_RST;
      err_cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) q0 <= enc;
          else               q1 <= enc;
          count <= count + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves q0 as-is so the head holds its value.
          if (count == 2'd2) q0 <= q1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) q0 <= enc;
          else begin
            q0 <= q1;
            q1 <= enc;
          end
        end
        default: ;
      endcase
      if (push && enc.err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (count != 2'd0);
  assign bus.a         = q0.a;
  assign bus.b         = q0.b;
  assign bus.en_n      = q0.en_n;
  assign bus.err       = q0.err;
  assign bus.err_cnt   = err_cnt;
endmodule
